hold_sequencer: RTL and testbench

HOLD_SEQUENCER -- requirements
Module: hold_sequencer

---
 rtl/hold_sequencer.sv | 72 +++++++
 tb/tb_hold_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hold_sequencer.sv
// Fills a SIZE-deep hold_value buffer one accepted sample per cycle, keeping a running sum,
// then presents the complete window (o_full) until downstream releases it.
module hold_sequencer #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 25
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    input  logic [WIDTH-1:0]                i_din,
    output logic                            o_ready,
    output logic [$clog2(SIZE)-1:0]         o_hv_enable,
    output logic [WIDTH-1:0]                o_hv_din,
    output logic [$clog2(SIZE+1)-1:0]       o_count,
    output logic [WIDTH+$clog2(SIZE)-1:0]   o_sum,
    output logic                            o_full,
    input  logic                            i_release
);
    localparam int EW = $clog2(SIZE);
    localparam int CW = $clog2(SIZE + 1);
    localparam int SW = WIDTH + EW;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {LOAD, COMMIT, FULL} state_t;
    state_t state, state_nxt;

    logic accept;
    logic win_clear;

    assign o_ready   = (state == LOAD);
    assign accept    = i_valid & o_ready;
    assign win_clear = (state == FULL) & i_release;

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && o_count == LAST) state_nxt = COMMIT;
            // One cycle for the final slot write to land in hold_value.
            COMMIT:  state_nxt = FULL;
            FULL:    if (i_release) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= LOAD;
            o_full <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_full <= (state_nxt == FULL);
        end
    end

    // Slot index/data hold when idle; hold_value simply rewrites the same slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hv_enable <= '0;
            o_hv_din    <= '0;
            o_count     <= '0;
            o_sum       <= '0;
        end else if (accept) begin
            o_hv_enable <= o_count[EW-1:0];
            o_hv_din    <= i_din;
            o_count     <= o_count + 1'b1;
            o_sum       <= o_sum + SW'(i_din);
        end else if (win_clear) begin
            o_count <= '0;
            o_sum   <= '0;
        end
    end
endmodule

// File: tb/tb_hold_sequencer.sv
// Directed bench for hold_sequencer: default instance plus a SIZE=9/WIDTH=10 instance.
module tb_hold_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, rel;
    logic [7:0]  din;
    logic        ready, full;
    logic [4:0]  hv_enable;
    logic [7:0]  hv_din;
    logic [4:0]  count;
    logic [12:0] sum;

    logic        s_valid, s_rel;
    logic [9:0]  s_din;
    logic        s_ready, s_full;
    logic [3:0]  s_hv_enable;
    logic [9:0]  s_hv_din;
    logic [3:0]  s_count;
    logic [13:0] s_sum;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [25];

    always #5 clk = ~clk;

    hold_sequencer u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_din(din),
        .o_ready(ready), .o_hv_enable(hv_enable), .o_hv_din(hv_din),
        .o_count(count), .o_sum(sum), .o_full(full), .i_release(rel)
    );

    hold_sequencer #(.WIDTH(10), .SIZE(9)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .i_din(s_din),
        .o_ready(s_ready), .o_hv_enable(s_hv_enable), .o_hv_din(s_hv_din),
        .o_count(s_count), .o_sum(s_sum), .o_full(s_full), .i_release(s_rel)
    );

    // Stand-in for hold_value: unconditional write of the addressed slot every edge.
    always @(posedge clk) begin
        if (hv_enable < 5'd25) mem[hv_enable] <= hv_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_window();
        rel = 1'b1;
        tick();
        rel = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid = 1'b0; rel = 1'b0; din = '0;
        s_valid = 1'b0; s_rel = 1'b0; s_din = '0;
        repeat (3) tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", ready); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0d expected 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (sum !== 13'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", sum); end
        checks++; if (hv_enable !== 5'd0 || hv_din !== 8'd0) begin errors++;
            $display("FAIL reset_hv: got en=%0d din=%0d expected 0/0", hv_enable, hv_din); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 25; k++) begin
            valid = 1'b1; din = 8'(k + 1);
            tick();
            checks++; if (hv_enable !== 5'(k) || hv_din !== 8'(k + 1) || count !== 5'(k + 1)) begin errors++;
                $display("FAIL b2b_slot%0d: got en=%0d din=%0d cnt=%0d expected %0d/%0d/%0d",
                         k, hv_enable, hv_din, count, k, k + 1, k + 1); end
        end
        valid = 1'b0;
        checks++; if (ready !== 1'b0 || full !== 1'b0) begin errors++;
            $display("FAIL b2b_commit: got ready=%0d full=%0d expected 0/0", ready, full); end
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %0d expected 1", full); end
        checks++; if (sum !== 13'd325) begin errors++; $display("FAIL b2b_sum: got %0d expected 325", sum); end
        checks++; if (count !== 5'd25) begin errors++; $display("FAIL b2b_count: got %0d expected 25", count); end
        tick();
        for (int k = 0; k < 25; k++) begin
            checks++; if (mem[k] !== 8'(k + 1)) begin errors++;
                $display("FAIL b2b_mem%0d: got %0d expected %0d", k, mem[k], k + 1); end
        end
    endtask

    task automatic test_backpressure();
        valid = 1'b1; din = 8'hAA;
        repeat (10) tick();
        checks++; if (count !== 5'd25 || full !== 1'b1 || ready !== 1'b0) begin errors++;
            $display("FAIL bp_hold: got cnt=%0d full=%0d ready=%0d expected 25/1/0", count, full, ready); end
        checks++; if (hv_enable !== 5'd24 || hv_din !== 8'd25 || mem[0] !== 8'd1) begin errors++;
            $display("FAIL bp_buffer: got en=%0d din=%0d mem0=%0d expected 24/25/1", hv_enable, hv_din, mem[0]); end
        release_window();
        checks++; if (ready !== 1'b1 || full !== 1'b0 || count !== 5'd0 || sum !== 13'd0) begin errors++;
            $display("FAIL bp_release: got ready=%0d full=%0d cnt=%0d sum=%0d expected 1/0/0/0", ready, full, count, sum); end
        checks++; if (hv_enable !== 5'd24 || hv_din !== 8'd25) begin errors++;
            $display("FAIL bp_release_hv: got en=%0d din=%0d expected 24/25", hv_enable, hv_din); end
        tick();
        checks++; if (hv_enable !== 5'd0 || hv_din !== 8'hAA || count !== 5'd1) begin errors++;
            $display("FAIL bp_first: got en=%0d din=%0d cnt=%0d expected 0/170/1", hv_enable, hv_din, count); end
        repeat (24) tick();
        valid = 1'b0;
        tick();
        checks++; if (full !== 1'b1 || sum !== 13'd4250) begin errors++;
            $display("FAIL bp_refill: got full=%0d sum=%0d expected 1/4250", full, sum); end
        checks++; if (mem[0] !== 8'hAA || mem[24] !== 8'hAA) begin errors++;
            $display("FAIL bp_mem: got mem0=%0d mem24=%0d expected 170/170", mem[0], mem[24]); end
        release_window();
    endtask

    task automatic test_bubbles();
        din = 8'd255;
        for (int i = 0; i < 50; i++) begin
            valid = (i % 2 == 0);
            tick();
            checks++; if (hv_enable !== 5'(i / 2) || hv_din !== 8'd255) begin errors++;
                $display("FAIL bubble_%0d: got en=%0d din=%0d expected %0d/255", i, hv_enable, hv_din, i / 2); end
        end
        valid = 1'b0;
        checks++; if (full !== 1'b1 || count !== 5'd25 || sum !== 13'd6375) begin errors++;
            $display("FAIL bubble_end: got full=%0d cnt=%0d sum=%0d expected 1/25/6375", full, count, sum); end
        release_window();
    endtask

    task automatic test_early_release();
        for (int k = 0; k < 25; k++) begin
            valid = 1'b1; din = 8'(k + 1); rel = (k == 12);
            tick();
            if (k == 12) begin
                checks++; if (count !== 5'd13 || ready !== 1'b1) begin errors++;
                    $display("FAIL early_load: got cnt=%0d ready=%0d expected 13/1", count, ready); end
            end
        end
        valid = 1'b0; rel = 1'b1;
        tick();
        rel = 1'b0;
        checks++; if (full !== 1'b1 || count !== 5'd25 || sum !== 13'd325) begin errors++;
            $display("FAIL early_commit: got full=%0d cnt=%0d sum=%0d expected 1/25/325", full, count, sum); end
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL early_stay: got %0d expected 1", full); end
        release_window();
    endtask

    task automatic test_reset_mid_load();
        valid = 1'b1; din = 8'd3;
        repeat (17) tick();
        valid = 1'b0;
        checks++; if (count !== 5'd17) begin errors++; $display("FAIL mid_pre: got %0d expected 17", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count !== 5'd0 || sum !== 13'd0 || hv_enable !== 5'd0 || hv_din !== 8'd0) begin errors++;
            $display("FAIL mid_async: got cnt=%0d sum=%0d en=%0d din=%0d expected 0/0/0/0", count, sum, hv_enable, hv_din); end
        checks++; if (ready !== 1'b1 || full !== 1'b0) begin errors++;
            $display("FAIL mid_async_flags: got ready=%0d full=%0d expected 1/0", ready, full); end
        #1 rst_n = 1'b1;
        tick();
        valid = 1'b1; din = 8'd2;
        tick();
        checks++; if (hv_enable !== 5'd0 || count !== 5'd1) begin errors++;
            $display("FAIL mid_refill_first: got en=%0d cnt=%0d expected 0/1", hv_enable, count); end
        repeat (24) tick();
        valid = 1'b0;
        tick();
        checks++; if (full !== 1'b1 || sum !== 13'd50) begin errors++;
            $display("FAIL mid_refill_end: got full=%0d sum=%0d expected 1/50", full, sum); end
        release_window();
    endtask

    task automatic test_param_sweep();
        s_valid = 1'b1; s_din = 10'd1023;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 7) begin
                checks++; if (s_full !== 1'b0 || s_ready !== 1'b1) begin errors++;
                    $display("FAIL sweep_mid: got full=%0d ready=%0d expected 0/1", s_full, s_ready); end
            end
        end
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0 || s_count !== 4'd9 || s_hv_enable !== 4'd8) begin errors++;
            $display("FAIL sweep_last: got ready=%0d cnt=%0d en=%0d expected 0/9/8", s_ready, s_count, s_hv_enable); end
        tick();
        checks++; if (s_full !== 1'b1 || s_sum !== 14'd9207) begin errors++;
            $display("FAIL sweep_full: got full=%0d sum=%0d expected 1/9207", s_full, s_sum); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_early_release();
        test_reset_mid_load();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
